shifter_unit: RTL

//  Multi-cycle, parametrised shift unit; successor to the fixed shift-left-by-2 helper.
//  - Shifts a WIDTH-bit operand by a runtime amount, using SLL/SRL/SRA (plus ROL when enabled).
//  - Each cycle shifts by at most STEP bits.
//  - Valid/ready handshakes on both sides; sits beside the ALU for variable-shift instructions.

---
 rtl/shifter_pkg.sv | 15 +
 rtl/shifter_step.sv | 34 +++
 rtl/shifter_unit.sv | 89 ++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the multi-cycle shift unit: op encodings and FSM states.
package shifter_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shifter_step.sv
// One shift step: moves the operand by k (0..STEP) bits for the given op.
// Purely combinational; no handshake. Rotate path exists only with SHIFTER_ROTATE_EN.
// Without SHIFTER_ROTATE_EN, op 11 falls through to a logical left shift.
module shifter_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int KW    = 3
) (
  input  logic [WIDTH-1:0] data,
  input  logic [KW-1:0]    k,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result
);

`ifdef SHIFTER_ROTATE_EN
  logic [2*WIDTH-1:0] rot_wide;
  assign rot_wide = {data, data} << k;
`endif

  always_comb begin
    result = data << k;
    case (op)
      OP_SRL: result = data >> k;
      OP_SRA: result = $unsigned($signed(data) >>> k);
`ifdef SHIFTER_ROTATE_EN
      // Upper half of the doubled word is the operand rotated left by k.
      OP_ROL: result = rot_wide[2*WIDTH-1:WIDTH];
`endif
      default: result = data << k;
    endcase
  end

endmodule

// File: rtl/shifter_unit.sv
// Variable shift unit (SLL/SRL/SRA, ROL with SHIFTER_ROTATE_EN), at most STEP bits per cycle.
// Latency: out_valid_o rises 1+ceil(shamt/STEP) cycles after the accept edge.
// Backpressure: result held in DONE until out_ready_i; no new request accepted until back in IDLE.
module shifter_unit
  import shifter_pkg::*;
#(
  parameter int  WIDTH = 32,
  parameter int  STEP  = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shamt_i,
  input  logic [1:0]       op_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o
);

  localparam int KW = $clog2(STEP + 1);

  state_t           state;
  logic [SHW-1:0]   remaining;
  logic [WIDTH-1:0] acc;
  logic [1:0]       op_q;
  logic [SHW-1:0]   k_full;
  logic [WIDTH-1:0] step_res;

  assign k_full = (remaining > SHW'(STEP)) ? SHW'(STEP) : remaining;

  shifter_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .data   (acc),
    .k      (k_full[KW-1:0]),
    .op     (op_q),
    .result (step_res)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= S_IDLE;
      remaining   <= '0;
      acc         <= '0;
      op_q        <= OP_SLL;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      data_o      <= '0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid_i && in_ready_o) begin
            acc        <= data_i;
            remaining  <= shamt_i;
            op_q       <= op_i;
            in_ready_o <= 1'b0;
            busy_o     <= 1'b1;
            state      <= (shamt_i == '0) ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          acc       <= step_res;
          remaining <= remaining - k_full;
          if (remaining == k_full) state <= S_DONE;
        end
        S_DONE: begin
          // First DONE cycle publishes the result; later cycles wait for the consumer.
          if (!out_valid_o) begin
            out_valid_o <= 1'b1;
            data_o      <= acc;
          end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            busy_o      <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
